// File: rtl/audio_playback_ctrl_if.sv
// Flash read bus between audio_playback_ctrl (master) and the flash controller (slave).
// Avalon-style: read is held while waitrequest=1; data returns later with readdatavalid.
interface audio_playback_ctrl_if;
  logic        read;
  logic [22:0] addr;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output read, addr,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, addr,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/audio_playback_ctrl.sv
// audio_playback_ctrl: fetches 32-bit words from flash and releases them as two
// 16-bit samples, one per accepted sample_tick, under keyboard play/pause,
// direction and restart control.
// Optional build macro MUTE_ON_PAUSE_EN: while paused with a word ready, each tick
// emits a zero sample so the output stage sees a steady silent stream.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH      | raise the read request for flash_addr
// WAIT_GRANT | hold the request until the slave drops waitrequest
// WAIT_DATA  | wait for readdatavalid, latch the word
// OUT_FIRST  | release the first half on the next accepted tick
// OUT_SECOND | release the other half on the next accepted tick
// ADVANCE    | step/wrap the address or apply a pending restart
module audio_playback_ctrl #(
  parameter logic [22:0] ADDR_MAX    = 23'h7FFFF,
  parameter logic [7:0]  KEY_PAUSE   = 8'h23,
  parameter logic [7:0]  KEY_PLAY    = 8'h24,
  parameter logic [7:0]  KEY_FWD     = 8'h46,
  parameter logic [7:0]  KEY_BWD     = 8'h42,
  parameter logic [7:0]  KEY_RESTART = 8'h52
) (
  input  logic                         clock50,
  input  logic                         rst,
  input  logic [7:0]                   key_control,
  input  logic                         sample_tick,
  audio_playback_ctrl_if.master        flash,
  output logic [15:0]                  audio_data,
  output logic                         audio_valid,
  output logic                         playing,
  output logic                         direction
);

  typedef enum logic [2:0] {
    FETCH,
    WAIT_GRANT,
    WAIT_DATA,
    OUT_FIRST,
    OUT_SECOND,
    ADVANCE
  } state_t;

  state_t      state_q, state_d;
  logic        flash_read_q, flash_read_d;
  logic [22:0] flash_addr_q, flash_addr_d;
  logic [31:0] word_q, word_d;
  logic [15:0] audio_data_q, audio_data_d;
  logic        audio_valid_q, audio_valid_d;
  logic        playing_q, playing_d;
  logic        direction_q, direction_d;
  logic        restart_pending_q, restart_pending_d;
  logic        dir_word_q, dir_word_d;
  logic        tick_ok;

  // A tick right after a released sample is ignored so audio_valid can never
  // be high on back-to-back cycles, even if the strobe is stretched.
  assign tick_ok = sample_tick && !audio_valid_q;

  // Register update with synchronous reset.
  always_ff @(posedge clock50) begin
    if (rst) begin
      state_q           <= FETCH;
      flash_read_q      <= 1'b0;
      flash_addr_q      <= '0;
      word_q            <= '0;
      audio_data_q      <= '0;
      audio_valid_q     <= 1'b0;
      playing_q         <= 1'b0;
      direction_q       <= 1'b1;
      restart_pending_q <= 1'b0;
      dir_word_q        <= 1'b1;
    end else begin
      state_q           <= state_d;
      flash_read_q      <= flash_read_d;
      flash_addr_q      <= flash_addr_d;
      word_q            <= word_d;
      audio_data_q      <= audio_data_d;
      audio_valid_q     <= audio_valid_d;
      playing_q         <= playing_d;
      direction_q       <= direction_d;
      restart_pending_q <= restart_pending_d;
      dir_word_q        <= dir_word_d;
    end
  end

  // Key decode, next-state and registered-output computation.
  always_comb begin
    state_d           = state_q;
    flash_read_d      = flash_read_q;
    flash_addr_d      = flash_addr_q;
    word_d            = word_q;
    audio_data_d      = audio_data_q;
    audio_valid_d     = 1'b0;
    playing_d         = playing_q;
    direction_d       = direction_q;
    restart_pending_d = restart_pending_q;
    dir_word_d        = dir_word_q;

    case (key_control)
      KEY_PLAY:    playing_d         = 1'b1;
      KEY_PAUSE:   playing_d         = 1'b0;
      KEY_FWD:     direction_d       = 1'b1;
      KEY_BWD:     direction_d       = 1'b0;
      KEY_RESTART: restart_pending_d = 1'b1;
      default:     ;
    endcase

    case (state_q)
      FETCH: begin
        flash_read_d = 1'b1;
        state_d      = WAIT_GRANT;
      end
      WAIT_GRANT: begin
        if (!flash.waitrequest) begin
          flash_read_d = 1'b0;
          state_d      = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (flash.readdatavalid) begin
          word_d  = flash.readdata;
          state_d = OUT_FIRST;
        end
      end
      OUT_FIRST: begin
        if (tick_ok && playing_q) begin
          // Direction is frozen here so both halves come out in a consistent order.
          dir_word_d    = direction_q;
          audio_data_d  = direction_q ? word_q[15:0] : word_q[31:16];
          audio_valid_d = 1'b1;
          state_d       = OUT_SECOND;
        end
`ifdef MUTE_ON_PAUSE_EN
        else if (tick_ok) begin
          audio_data_d  = 16'h0000;
          audio_valid_d = 1'b1;
        end
`endif
      end
      OUT_SECOND: begin
        if (tick_ok && playing_q) begin
          audio_data_d  = dir_word_q ? word_q[31:16] : word_q[15:0];
          audio_valid_d = 1'b1;
          state_d       = ADVANCE;
        end
`ifdef MUTE_ON_PAUSE_EN
        else if (tick_ok) begin
          audio_data_d  = 16'h0000;
          audio_valid_d = 1'b1;
        end
`endif
      end
      ADVANCE: begin
        if (restart_pending_q) begin
          flash_addr_d      = direction_q ? 23'd0 : ADDR_MAX;
          restart_pending_d = 1'b0;
        end else if (direction_q) begin
          flash_addr_d = (flash_addr_q == ADDR_MAX) ? 23'd0 : flash_addr_q + 23'd1;
        end else begin
          flash_addr_d = (flash_addr_q == 23'd0) ? ADDR_MAX : flash_addr_q - 23'd1;
        end
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign flash.read  = flash_read_q;
  assign flash.addr  = flash_addr_q;
  assign audio_data  = audio_data_q;
  assign audio_valid = audio_valid_q;
  assign playing     = playing_q;
  assign direction   = direction_q;

endmodule
